// File: rtl/gmii_tx_mac_pkg.sv
// Shared Ethernet transmit definitions for the GMII transmit MAC.
// Holds the transmit FSM state encoding, the preamble/SFD byte values,
// the CRC-32 seed and polynomial (normal and bit-reflected form).
package gmii_tx_mac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SFD,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_IFG
  } tx_state_e;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_POLY    = 32'h04C1_1DB7;

  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // Ethernet shifts LSB first, so the update uses the reflected polynomial.
  localparam logic [31:0] CRC32_POLY_REFL = bitrev32(CRC32_POLY);

endpackage

// File: rtl/gmii_tx_mac_if.sv
// Byte-stream source interface feeding the GMII transmit MAC.
//   in_valid : source byte valid
//   in_data  : payload byte
//   in_last  : final byte of frame
//   in_ready : byte accepted when in_valid && in_ready
// master = byte source, slave = MAC.
interface gmii_tx_mac_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_ready;

  modport master (output in_valid, output in_data, output in_last, input in_ready);
  modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/gmii_tx_mac_crc32_byte.sv
// Combinational byte-wide Ethernet CRC-32 update (reflected, LSB first).
//   crc_i  : running CRC register value
//   data_i : byte to absorb
//   crc_o  : CRC after absorbing data_i
module crc32_byte
  import gmii_tx_mac_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  always_comb begin
    crc_o = crc_i ^ {24'd0, data_i};
    for (int i = 0; i < 8; i++) begin
      crc_o = crc_o[0] ? ((crc_o >> 1) ^ CRC32_POLY_REFL) : (crc_o >> 1);
    end
  end

endmodule

// File: rtl/gmii_tx_mac.sv
// GMII transmit MAC: wraps a source byte stream into an Ethernet frame
// (preamble, SFD, payload, zero pad to MIN_FRAME, CRC-32 FCS) and enforces
// IFG_BYTES idle cycles between frames.
//   gmii_txc   : 125 MHz byte clock, the only clock
//   rst_n      : asynchronous active-low reset, release synchronised
//   link_up    : new frames may start only while high
//   src        : byte-stream slave port (in_valid/in_data/in_last/in_ready)
//   gmii_txd/gmii_tx_en/gmii_tx_er : registered GMII transmit outputs
// Optional macro GMII_TX_STATS_EN adds frames_sent / frames_err counters.
module gmii_tx_mac
  import gmii_tx_mac_pkg::*;
#(
  parameter int MIN_FRAME = 60,
  parameter int IFG_BYTES = 12
) (
  input  logic          gmii_txc,
  input  logic          rst_n,
  input  logic          link_up,
  gmii_tx_mac_if.slave  src,
  output logic [7:0]    gmii_txd,
  output logic          gmii_tx_en,
  output logic          gmii_tx_er
`ifdef GMII_TX_STATS_EN
  ,
  output logic [31:0]   frames_sent,
  output logic [31:0]   frames_err
`endif
);

  localparam logic [10:0] MIN_CNT  = 11'(MIN_FRAME);
  localparam logic [15:0] IFG_LAST = 16'(IFG_BYTES - 1);

  tx_state_e   state_q;
  logic [1:0]  sync_q;
  logic [10:0] cnt_q;
  logic [15:0] aux_q;
  logic [31:0] crc_q;
  logic [31:0] crc_d;
  logic        err_q;
  logic [7:0]  txd_q;
  logic        en_q;
  logic        er_q;
  logic        rdy_q;
  logic [7:0]  crc_din;
  logic [10:0] cnt_inc;
  logic [10:0] cnt_after;
  logic [31:0] fcs;

  // Reset release reaches the FSM through two flops; assertion is immediate.
  always_ff @(posedge gmii_txc or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], 1'b1};
  end

  assign crc_din   = (state_q == ST_DATA) ? src.in_data : 8'h00;
  assign cnt_inc   = (cnt_q == 11'h7FF) ? cnt_q : cnt_q + 11'd1;
  // After an underrun the drained bytes are not transmitted, so not counted.
  assign cnt_after = err_q ? cnt_q : cnt_inc;
  assign fcs       = ~crc_q;

  crc32_byte u_crc (
    .crc_i  (crc_q),
    .data_i (crc_din),
    .crc_o  (crc_d)
  );

`ifdef GMII_TX_STATS_EN
  logic [31:0] sent_q;
  logic [31:0] errc_q;
  assign frames_sent = sent_q;
  assign frames_err  = errc_q;
`endif

  always_ff @(posedge gmii_txc or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      aux_q   <= '0;
      crc_q   <= CRC32_INIT;
      err_q   <= 1'b0;
      txd_q   <= 8'h00;
      en_q    <= 1'b0;
      er_q    <= 1'b0;
      rdy_q   <= 1'b0;
`ifdef GMII_TX_STATS_EN
      sent_q  <= '0;
      errc_q  <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          en_q  <= 1'b0;
          er_q  <= 1'b0;
          txd_q <= 8'h00;
          rdy_q <= 1'b0;
          if (sync_q[1] && link_up && src.in_valid) begin
            state_q <= ST_PREAMBLE;
            en_q    <= 1'b1;
            txd_q   <= PREAMBLE_BYTE;
            aux_q   <= 16'd1;
            cnt_q   <= '0;
            crc_q   <= CRC32_INIT;
            err_q   <= 1'b0;
          end
        end
        ST_PREAMBLE: begin
          txd_q <= PREAMBLE_BYTE;
          aux_q <= aux_q + 16'd1;
          if (aux_q == 16'd6) state_q <= ST_SFD;
        end
        ST_SFD: begin
          txd_q   <= SFD_BYTE;
          rdy_q   <= 1'b1;
          state_q <= ST_DATA;
        end
        ST_DATA: begin
          if (!src.in_valid) begin
            // Source starved: flag the frame bad for the rest of its length.
            err_q <= 1'b1;
            er_q  <= 1'b1;
            txd_q <= 8'h00;
          end else begin
            er_q <= err_q;
            if (err_q) begin
              txd_q <= 8'h00;
            end else begin
              txd_q <= src.in_data;
              crc_q <= crc_d;
              cnt_q <= cnt_inc;
            end
            if (src.in_last) begin
              rdy_q   <= 1'b0;
              aux_q   <= '0;
              state_q <= (cnt_after < MIN_CNT) ? ST_PAD : ST_FCS;
            end
          end
        end
        ST_PAD: begin
          txd_q <= 8'h00;
          er_q  <= err_q;
          crc_q <= crc_d;
          cnt_q <= cnt_inc;
          if (cnt_inc >= MIN_CNT) state_q <= ST_FCS;
        end
        ST_FCS: begin
          txd_q <= fcs[{aux_q[1:0], 3'b000} +: 8];
          er_q  <= err_q;
          aux_q <= aux_q + 16'd1;
          if (aux_q[1:0] == 2'd3) begin
            state_q <= ST_IFG;
            aux_q   <= '0;
`ifdef GMII_TX_STATS_EN
            sent_q  <= sent_q + 32'd1;
            if (err_q) errc_q <= errc_q + 32'd1;
`endif
          end
        end
        ST_IFG: begin
          en_q  <= 1'b0;
          er_q  <= 1'b0;
          txd_q <= 8'h00;
          err_q <= 1'b0;
          aux_q <= aux_q + 16'd1;
          if (aux_q == IFG_LAST) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign src.in_ready = rdy_q;
  assign gmii_txd     = txd_q;
  assign gmii_tx_en   = en_q;
  assign gmii_tx_er   = er_q;

endmodule
